// File: rtl/plic_mctx_core_if.sv
// rtl/plic_mctx_core_if.sv - Register-file-side signal bundle for plic_mctx_core
interface plic_mctx_core_if #(
  parameter int NSRC       = 32,
  parameter int NCTX       = 2,
  parameter int PRIO_WIDTH = 3,
  parameter int ID_WIDTH   = $clog2(NSRC)
);
  logic [NSRC-1:0]            irq_i;
  logic [NSRC-1:0]            mode_i;
  logic [NSRC*PRIO_WIDTH-1:0] prio_i;
  logic [NCTX*NSRC-1:0]       ie_i;
  logic [NCTX*PRIO_WIDTH-1:0] thold_i;
  logic [NCTX-1:0]            claim_i;
  logic [NCTX-1:0]            complete_i;
  logic [NCTX*ID_WIDTH-1:0]   comp_id_i;
  logic [NSRC-1:0]            ip_o;
  logic [NCTX*ID_WIDTH-1:0]   claim_id_o;
  logic [NCTX-1:0]            irq_o;

  modport master (
    output irq_i, mode_i, prio_i, ie_i, thold_i, claim_i, complete_i, comp_id_i,
    input  ip_o, claim_id_o, irq_o
  );

  modport slave (
    input  irq_i, mode_i, prio_i, ie_i, thold_i, claim_i, complete_i, comp_id_i,
    output ip_o, claim_id_o, irq_o
  );
endinterface

// File: rtl/plic_mctx_core.sv
// rtl/plic_mctx_core.sv - Multi-context PLIC core: gateways, edge counters, per-context arbiters
module plic_mctx_core #(
  parameter int NSRC           = 32,
  parameter int NCTX           = 2,
  parameter int PRIO_WIDTH     = 3,
  parameter int EDGE_CNT_WIDTH = 2
) (
  input logic             clk_i,
  input logic             rst_i,
  plic_mctx_core_if.slave bus
);
  localparam int ID_WIDTH = $clog2(NSRC);
  localparam int NSRC_P2  = 1 << ID_WIDTH;
  localparam logic [EDGE_CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [NSRC-1:0] SRC_MASK = {{(NSRC-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PEND    = 2'd1,
    ST_CLAIMED = 2'd2
  } gw_state_e;

  gw_state_e                 r_state [NSRC];
  logic [EDGE_CNT_WIDTH-1:0] r_cnt [NSRC];
  logic [NSRC-1:0]           r_irq_q;
  logic [ID_WIDTH-1:0]       r_best_id [NCTX];
  logic [PRIO_WIDTH-1:0]     r_best_prio [NCTX];

  logic [NSRC-1:0]           w_irq;
  logic [NSRC-1:0]           w_mode;
  logic [NSRC-1:0]           w_edge;
  logic [NSRC-1:0]           w_pend;
  logic [NSRC_P2-1:0]        w_pend_ext;
  logic [NSRC-1:0]           w_claim_hit;
  logic [NSRC-1:0]           w_comp_hit;
  logic [NCTX-1:0]           w_valid;
  logic [ID_WIDTH-1:0]       w_claim_id [NCTX];
  logic [NCTX*ID_WIDTH-1:0]  w_claim_id_flat;
  logic [ID_WIDTH-1:0]       w_arb_id [NCTX];
  logic [PRIO_WIDTH-1:0]     w_arb_prio [NCTX];

  // Source 0 is masked at the input so its gateway can never leave IDLE.
  assign w_irq  = bus.irq_i & SRC_MASK;
  assign w_mode = bus.mode_i & SRC_MASK;
  assign w_edge = w_irq & ~r_irq_q;

  always_comb begin
    for (int s = 0; s < NSRC; s++) begin
      w_pend[s] = (r_state[s] == ST_PEND);
    end
  end

  assign w_pend_ext = NSRC_P2'(w_pend);

  // Upward scan with strict '>' keeps the lowest ID on equal priority.
  always_comb begin
    for (int c = 0; c < NCTX; c++) begin
      w_arb_id[c]   = '0;
      w_arb_prio[c] = '0;
      for (int s = 0; s < NSRC; s++) begin
        if (w_pend[s] && bus.ie_i[c*NSRC+s] &&
            (bus.prio_i[s*PRIO_WIDTH +: PRIO_WIDTH] > w_arb_prio[c])) begin
          w_arb_id[c]   = ID_WIDTH'(s);
          w_arb_prio[c] = bus.prio_i[s*PRIO_WIDTH +: PRIO_WIDTH];
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NCTX; c++) begin
      w_valid[c] = (r_best_prio[c] > bus.thold_i[c*PRIO_WIDTH +: PRIO_WIDTH]) &&
                   w_pend_ext[r_best_id[c]];
    end
  end

  // A lower-index context claiming the same ID in this cycle takes it.
  always_comb begin
    w_claim_hit = '0;
    for (int c = 0; c < NCTX; c++) begin
      w_claim_id[c] = w_valid[c] ? r_best_id[c] : '0;
      if (bus.claim_i[c]) begin
        for (int k = 0; k < c; k++) begin
          if (bus.claim_i[k] && w_valid[k] && (r_best_id[k] == r_best_id[c])) begin
            w_claim_id[c] = '0;
          end
        end
      end
      for (int s = 1; s < NSRC; s++) begin
        if (bus.claim_i[c] && (w_claim_id[c] == ID_WIDTH'(s))) begin
          w_claim_hit[s] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_comp_hit = '0;
    for (int s = 1; s < NSRC; s++) begin
      for (int c = 0; c < NCTX; c++) begin
        if (bus.complete_i[c] && (bus.comp_id_i[c*ID_WIDTH +: ID_WIDTH] == ID_WIDTH'(s)) &&
            bus.ie_i[c*NSRC+s] && (r_state[s] == ST_CLAIMED)) begin
          w_comp_hit[s] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NCTX; c++) begin
      w_claim_id_flat[c*ID_WIDTH +: ID_WIDTH] = w_claim_id[c];
    end
  end

  assign bus.ip_o       = w_pend;
  assign bus.irq_o      = w_valid;
  assign bus.claim_id_o = w_claim_id_flat;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_irq_q <= '0;
      for (int s = 0; s < NSRC; s++) begin
        r_state[s] <= ST_IDLE;
        r_cnt[s]   <= '0;
      end
      for (int c = 0; c < NCTX; c++) begin
        r_best_id[c]   <= '0;
        r_best_prio[c] <= '0;
      end
    end else begin
      r_irq_q <= w_irq;
      for (int c = 0; c < NCTX; c++) begin
        r_best_id[c]   <= w_arb_id[c];
        r_best_prio[c] <= w_arb_prio[c];
      end
      for (int s = 0; s < NSRC; s++) begin
        case (r_state[s])
          ST_IDLE: begin
            if (w_mode[s] ? w_edge[s] : w_irq[s]) r_state[s] <= ST_PEND;
          end
          ST_PEND: begin
            if (w_claim_hit[s]) r_state[s] <= ST_CLAIMED;
          end
          ST_CLAIMED: begin
            if (w_comp_hit[s]) begin
              r_state[s] <= (w_mode[s] && ((r_cnt[s] != '0) || w_edge[s])) ? ST_PEND : ST_IDLE;
            end
          end
          default: r_state[s] <= ST_IDLE;
        endcase

        // An edge coinciding with a complete replaces the decrement (or the re-pend at count 0).
        if (!w_mode[s]) begin
          r_cnt[s] <= '0;
        end else if (w_edge[s] && (r_state[s] != ST_IDLE)) begin
          if (!w_comp_hit[s] && (r_cnt[s] != CNT_MAX)) r_cnt[s] <= r_cnt[s] + 1'b1;
        end else if (w_comp_hit[s] && (r_cnt[s] != '0)) begin
          r_cnt[s] <= r_cnt[s] - 1'b1;
        end
      end
    end
  end
endmodule
